// File: rtl/asrv32_fetch_pkg.sv
// asrv32 fetch shared definitions: FSM state encodings, widths, reset PC default, PC helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package asrv32_fetch_pkg;

  localparam int XLEN = 32;

  // Fetch FSM encodings (kept as plain constants for older tool flows)
  localparam logic [1:0] ST_FETCH = 2'd0;  // stb high, waiting for ack
  localparam logic [1:0] ST_HOLD  = 2'd1;  // skid full, stb low
  localparam logic [1:0] ST_FLUSH = 2'd2;  // redirect seen with a request still outstanding

  localparam logic [XLEN-1:0] PC_RESET_DEF = 32'h0000_0000;

  // Sequential next PC; natural 32-bit wrap from 0xFFFF_FFFC to 0.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  // Force a redirect target onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/asrv32_fetch_skid.sv
// One-entry {inst,pc} holding buffer behind the fetch output register.
// Latency: loaded value visible the cycle after i_load; drain/clear empty it on the next edge.
// Backpressure: none of its own; the owner stops requesting memory while o_full is set.
module asrv32_fetch_skid
  import asrv32_fetch_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_clr,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_full,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc
);

  logic            full_q, full_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Clear beats load beats drain; the owner never loads and drains together.
  always_comb begin
    full_d = full_q;
    inst_d = inst_q;
    pc_d   = pc_q;
    if (i_clr) begin
      full_d = 1'b0;
    end else if (i_load) begin
      full_d = 1'b1;
      inst_d = i_inst;
      pc_d   = i_pc;
    end else if (i_drain) begin
      full_d = 1'b0;
    end
  end

  // Buffer state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
    end else begin
      full_q <= full_d;
      inst_q <= inst_d;
      pc_q   <= pc_d;
    end
  end

  assign o_full = full_q;
  assign o_inst = inst_q;
  assign o_pc   = pc_q;

endmodule

// File: rtl/asrv32_fetch.sv
// Instruction fetch: one outstanding stb/ack request, output register + 1-entry skid, redirect flush.
// Latency: a word acked at edge N is on o_inst after edge N (or after the skid drains); ack latency unbounded.
// Backpressure: i_stall holds the outputs; a second word goes to the skid and stb drops until it drains.
// Optional: ASRV32_FETCH_MISALIGN_EN adds o_misaligned and suppresses fetch on unaligned redirect targets.
module asrv32_fetch
  import asrv32_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic [XLEN-1:0] o_iaddr,
  output logic            o_stb_inst,
  input  logic            i_ack_inst,
  input  logic [XLEN-1:0] i_inst,
  input  logic            i_stall,
  input  logic            i_change_pc,
  input  logic [XLEN-1:0] i_new_pc,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid
`ifdef ASRV32_FETCH_MISALIGN_EN
  ,
  output logic            o_misaligned
`endif
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;      // current request address
  logic [XLEN-1:0] tgt_q, tgt_d;    // redirect target latched during FLUSH
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic            stb_q, stb_d;
  logic            vld_q, vld_d;
  logic            mis_q, mis_d;

  logic            ack;
  logic            accept;
  logic            new_mis;
  logic [XLEN-1:0] new_pc_al;
  logic            skid_load, skid_drain, skid_clr, skid_full;
  logic [XLEN-1:0] skid_inst, skid_pc;

  // Acks with no strobe (e.g. left over from before a reset) are ignored.
  assign ack       = i_ack_inst & stb_q;
  assign accept    = vld_q & ~i_stall;
  assign new_pc_al = word_align(i_new_pc);

`ifdef ASRV32_FETCH_MISALIGN_EN
  assign new_mis = |i_new_pc[1:0];
`else
  logic new_pc_unused;
  assign new_mis       = 1'b0;
  assign new_pc_unused = ^i_new_pc[1:0];
`endif

  // Next-state for PC, strobe, FSM and output register; redirect overrides stall and ack.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    inst_d     = inst_q;
    opc_d      = opc_q;
    stb_d      = stb_q;
    vld_d      = vld_q;
    mis_d      = mis_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clr   = 1'b0;
    if (i_change_pc) begin
      vld_d    = 1'b0;
      skid_clr = 1'b1;
      mis_d    = new_mis;
      if (new_mis) opc_d = i_new_pc;
      if (stb_q && !ack) begin
        // Memory still owes us a word: keep the old address up until it arrives, then go.
        state_d = ST_FLUSH;
        tgt_d   = new_pc_al;
        stb_d   = 1'b1;
      end else begin
        // Nothing outstanding (or the ack lands now and is dropped): fetch the target next cycle.
        state_d = ST_FETCH;
        pc_d    = new_pc_al;
        stb_d   = ~new_mis;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (ack) begin
            pc_d = pc_inc(pc_q);
            if (!vld_q || accept) begin
              inst_d = i_inst;
              opc_d  = pc_q;
              vld_d  = 1'b1;
              stb_d  = 1'b1;
            end else begin
              skid_load = 1'b1;
              stb_d     = 1'b0;
              state_d   = ST_HOLD;
            end
          end else begin
            if (accept) vld_d = 1'b0;
            stb_d = ~mis_q;
          end
        end
        ST_HOLD: begin
          if (accept) begin
            inst_d     = skid_inst;
            opc_d      = skid_pc;
            vld_d      = 1'b1;
            skid_drain = 1'b1;
            stb_d      = 1'b1;
            state_d    = ST_FETCH;
          end
        end
        ST_FLUSH: begin
          if (ack) begin
            pc_d    = tgt_q;
            stb_d   = ~mis_q;
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // Fetch state registers; reset leaves stb low so the first request rises one cycle after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_RESET;
      tgt_q   <= PC_RESET;
      inst_q  <= '0;
      opc_q   <= '0;
      stb_q   <= 1'b0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      stb_q   <= stb_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
    end
  end

  asrv32_fetch_skid u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (skid_load),
    .i_drain (skid_drain),
    .i_clr   (skid_clr),
    .i_inst  (i_inst),
    .i_pc    (pc_q),
    .o_full  (skid_full),
    .o_inst  (skid_inst),
    .o_pc    (skid_pc)
  );

  assign o_iaddr    = pc_q;
  assign o_stb_inst = stb_q & ~skid_full;
  assign o_inst     = inst_q;
  assign o_pc       = opc_q;
  assign o_valid    = vld_q;
`ifdef ASRV32_FETCH_MISALIGN_EN
  assign o_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_asrv32_fetch.sv
// Bench for asrv32_fetch: behavioural memory with random ack latency, random stall, redirects.
// Reference: accepted words must form pc, pc+4, ... from the last redirect target with inst = memf(pc).
// Also checks stall hold, address stability while waiting, and the directed reset/flush scenarios.
module tb_asrv32_fetch;

  localparam logic [31:0] PCR = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [31:0] o_iaddr;
  logic        o_stb_inst;
  logic        i_ack_inst = 1'b0;
  logic [31:0] i_inst = 32'h0;
  logic        i_stall = 1'b0;
  logic        i_change_pc = 1'b0;
  logic [31:0] i_new_pc = 32'h0;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_valid;
`ifdef ASRV32_FETCH_MISALIGN_EN
  logic        o_misaligned;
`endif

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          cnt = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          stall_pct = 0;
  int          acc_cnt = 0;
  logic [31:0] exp_pc = PCR;

  asrv32_fetch #(.PC_RESET(PCR)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_iaddr     (o_iaddr),
    .o_stb_inst  (o_stb_inst),
    .i_ack_inst  (i_ack_inst),
    .i_inst      (i_inst),
    .i_stall     (i_stall),
    .i_change_pc (i_change_pc),
    .i_new_pc    (i_new_pc),
    .o_inst      (o_inst),
    .o_pc        (o_pc),
    .o_valid     (o_valid)
`ifdef ASRV32_FETCH_MISALIGN_EN
    ,
    .o_misaligned(o_misaligned)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: reference checks before the edge, property checks after it, then drive memory/stall.
  task automatic step();
    logic        acc, hold, redir, waitreq;
    logic [31:0] p_inst, p_pc, p_addr, rtgt;
    acc     = o_valid && !i_stall;
    hold    = o_valid && i_stall && !i_change_pc;
    redir   = i_change_pc;
    rtgt    = i_new_pc;
    waitreq = o_stb_inst && !i_ack_inst;
    p_addr  = o_iaddr;
    p_inst  = o_inst;
    p_pc    = o_pc;
    if (acc) begin
      chk("acc_pc", o_pc, exp_pc);
      chk("acc_inst", o_inst, memf(exp_pc));
      exp_pc += 32'd4;
      acc_cnt++;
    end
    if (redir) exp_pc = {rtgt[31:2], 2'b00};
    if (o_stb_inst && !i_ack_inst) cnt++;
    @(posedge i_clk);
    #1;
    i_change_pc = 1'b0;
    if (redir) chk("redir_vld0", 32'(o_valid), 32'h0);
    if (hold) begin
      chk("stall_inst", o_inst, p_inst);
      chk("stall_pc", o_pc, p_pc);
      chk("stall_vld", 32'(o_valid), 32'h1);
    end
    if (waitreq) chk("addr_stable", o_iaddr, p_addr);
    chk("addr_align", 32'(o_iaddr[1:0]), 32'h0);
    if (i_ack_inst) begin
      i_ack_inst = 1'b0;
      cnt = 0;
      lat = int'($urandom_range(lat_max, lat_min));
    end else if (o_stb_inst && cnt >= lat) begin
      i_ack_inst = 1'b1;
      i_inst = memf(o_iaddr);
    end
    i_stall = (int'($urandom_range(99, 0)) < stall_pct);
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
  endtask

  initial begin
    int          start;
    logic [31:0] old_addr, r;

    // ---- reset values
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_iaddr", o_iaddr, PCR);
    chk("rst_stb", 32'(o_stb_inst), 32'h0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_vld", 32'(o_valid), 32'h0);
`ifdef ASRV32_FETCH_MISALIGN_EN
    chk("rst_mis", 32'(o_misaligned), 32'h0);
`endif
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // ---- 1: sequential fetch, ack one cycle after stb
    step();
    chk("t1_first_stb", 32'(o_stb_inst), 32'h1);
    chk("t1_first_addr", o_iaddr, PCR);
    for (int k = 0; k < 30 && acc_cnt < 3; k++) step();
    chk("t1_three_words", 32'(acc_cnt), 32'd3);

    // ---- 2: long stall, second word lands in skid
    stall_pct = 100;
    repeat (6) step();
    chk("t2_stb_low", 32'(o_stb_inst), 32'h0);
    chk("t2_vld_held", 32'(o_valid), 32'h1);
    chk("t2_pc_held", o_pc, exp_pc);
    stall_pct = 0;
    start = acc_cnt;
    for (int k = 0; k < 30 && acc_cnt < start + 3; k++) step();
    chk("t2_drain", 32'(acc_cnt - start), 32'd3);

    // ---- 3: redirect with request outstanding, ack 3 cycles later
    set_lat(3, 3);
    for (int k = 0; k < 30 && !(o_stb_inst && !i_ack_inst && cnt == 0 && lat == 3); k++) step();
    old_addr = o_iaddr;
    i_change_pc = 1'b1;
    i_new_pc = 32'h100;
    step();
    chk("t3_flush_stb", 32'(o_stb_inst), 32'h1);
    chk("t3_flush_addr", o_iaddr, old_addr);
    for (int k = 0; k < 30 && !(o_stb_inst && o_iaddr == 32'h100); k++) step();
    chk("t3_new_addr", o_iaddr, 32'h100);
    start = acc_cnt;
    for (int k = 0; k < 30 && acc_cnt == start; k++) step();
    chk("t3_got_word", 32'(acc_cnt - start), 32'd1);

    // ---- 4: redirect coinciding with ack, then back-to-back redirects
    set_lat(2, 2);
    for (int k = 0; k < 30 && !i_ack_inst; k++) step();
    chk("t4_ack_seen", 32'(i_ack_inst), 32'h1);
    i_change_pc = 1'b1;
    i_new_pc = 32'h200;
    step();
    chk("t4_direct_addr", o_iaddr, 32'h200);
    start = acc_cnt;
    for (int k = 0; k < 30 && acc_cnt == start; k++) step();
    set_lat(3, 3);
    for (int k = 0; k < 30 && !(o_stb_inst && !i_ack_inst && cnt == 0 && lat == 3); k++) step();
    i_change_pc = 1'b1;
    i_new_pc = 32'h300;
    step();
    i_change_pc = 1'b1;
    i_new_pc = 32'h400;
    step();
    for (int k = 0; k < 30 && !(o_stb_inst && o_iaddr == 32'h400); k++) step();
    chk("t4_last_wins", o_iaddr, 32'h400);
    start = acc_cnt;
    for (int k = 0; k < 30 && acc_cnt < start + 2; k++) step();
    chk("t4_words", 32'(acc_cnt - start), 32'd2);

    // ---- 5: PC wrap
    set_lat(1, 2);
    i_change_pc = 1'b1;
    i_new_pc = 32'hFFFF_FFFC;
    step();
    for (int k = 0; k < 30 && !(o_stb_inst && o_iaddr == 32'h0); k++) step();
    chk("t5_wrap_addr", o_iaddr, 32'h0);
    start = acc_cnt;
    for (int k = 0; k < 30 && acc_cnt < start + 2; k++) step();
    chk("t5_words", 32'(acc_cnt - start), 32'd2);

    // ---- 6: async reset in FLUSH, refetch, misaligned redirect
    set_lat(3, 3);
    for (int k = 0; k < 30 && !(o_stb_inst && !i_ack_inst && cnt == 0 && lat == 3); k++) step();
    i_change_pc = 1'b1;
    i_new_pc = 32'h500;
    step();
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_rst_iaddr", o_iaddr, PCR);
    chk("t6_rst_stb", 32'(o_stb_inst), 32'h0);
    chk("t6_rst_inst", o_inst, 32'h0);
    chk("t6_rst_pc", o_pc, 32'h0);
    chk("t6_rst_vld", 32'(o_valid), 32'h0);
    i_ack_inst = 1'b0;
    cnt = 0;
    lat = 1;
    set_lat(1, 1);
    exp_pc = PCR;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    step();
    chk("t6_refetch_stb", 32'(o_stb_inst), 32'h1);
    chk("t6_refetch_addr", o_iaddr, PCR);
    start = acc_cnt;
    for (int k = 0; k < 30 && acc_cnt < start + 2; k++) step();
    chk("t6_words", 32'(acc_cnt - start), 32'd2);

    i_change_pc = 1'b1;
    i_new_pc = 32'h102;
    step();
`ifdef ASRV32_FETCH_MISALIGN_EN
    chk("t6_mis_flag", 32'(o_misaligned), 32'h1);
    chk("t6_mis_pc", o_pc, 32'h102);
    repeat (6) step();
    chk("t6_mis_nostb", 32'(o_stb_inst), 32'h0);
    chk("t6_mis_hold", 32'(o_misaligned), 32'h1);
    chk("t6_mis_vld", 32'(o_valid), 32'h0);
    i_change_pc = 1'b1;
    i_new_pc = 32'h600;
    step();
    chk("t6_mis_clear", 32'(o_misaligned), 32'h0);
`else
    for (int k = 0; k < 30 && !(o_stb_inst && o_iaddr == 32'h100); k++) step();
    chk("t6_align_addr", o_iaddr, 32'h100);
`endif
    start = acc_cnt;
    for (int k = 0; k < 30 && acc_cnt < start + 2; k++) step();
    chk("t6_resume", 32'(acc_cnt - start), 32'd2);

    // ---- random traffic: random latency, stall, occasional aligned redirects
    set_lat(1, 4);
    stall_pct = 30;
    for (int k = 0; k < 800; k++) begin
      if (int'($urandom_range(99, 0)) < 3) begin
        r = $urandom();
        i_change_pc = 1'b1;
        i_new_pc = {r[31:2], 2'b00};
      end
      step();
    end
    stall_pct = 0;
    i_change_pc = 1'b1;
    i_new_pc = 32'h700;
    step();
    start = acc_cnt;
    for (int k = 0; k < 60 && acc_cnt < start + 4; k++) step();
    chk("rand_final_words", 32'(acc_cnt - start), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
